col_conf_ctrl: RTL and testbench

//  Configuration loader and run sequencer for one 8-PE column.

---
 rtl/col_conf_ctrl.sv | 215 +++++++++++++++++++++
 tb/tb_col_conf_ctrl.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/col_conf_ctrl.sv
// col_conf_ctrl: shadow/active configuration banks and RUN-window sequencer for one PE column.
// Optional CONF_READBACK_EN adds a registered active-bank readback port.
`default_nettype none

module col_conf_ctrl #(
  parameter int PE_NUM = 8,
  parameter int ALU_W  = 4,
  parameter int SEL_W  = 3,
  parameter int SE_W   = 2,
  parameter int DATA_W = 16,
  parameter int LEN_W  = 16,
  parameter int IDX_W  = $clog2(PE_NUM)
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       cfg_valid,
  output logic                       cfg_ready,
  input  logic [IDX_W-1:0]           cfg_pe,
  input  logic [2:0]                 cfg_field,
  input  logic [DATA_W-1:0]          cfg_data,
  input  logic                       commit,
  input  logic                       start,
  input  logic [LEN_W-1:0]           run_len,
  output logic [PE_NUM*ALU_W-1:0]    conf_alu,
  output logic [PE_NUM*SEL_W-1:0]    conf_sel_a,
  output logic [PE_NUM*SEL_W-1:0]    conf_sel_b,
  output logic [PE_NUM*SE_W-1:0]     conf_se,
  output logic [PE_NUM*DATA_W-1:0]   const_a,
  output logic [PE_NUM*DATA_W-1:0]   const_b,
`ifdef CONF_READBACK_EN
  input  logic [IDX_W-1:0]           rd_pe,
  input  logic [2:0]                 rd_field,
  output logic [DATA_W-1:0]          rd_data,
`endif
  output logic                       run,
  output logic                       done,
  output logic                       busy
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_SWAP = 2'd2
  } state_t;

  state_t            state, state_n;
  logic [LEN_W-1:0]  cnt, cnt_n;
  logic [LEN_W-1:0]  len_q, len_n;
  logic              pend, pend_n;
  logic              st_lat, st_lat_n;
  logic              done_n;

  logic [ALU_W-1:0]  sh_alu   [PE_NUM];
  logic [SEL_W-1:0]  sh_sel_a [PE_NUM];
  logic [SEL_W-1:0]  sh_sel_b [PE_NUM];
  logic [SE_W-1:0]   sh_se    [PE_NUM];
  logic [DATA_W-1:0] sh_ca    [PE_NUM];
  logic [DATA_W-1:0] sh_cb    [PE_NUM];

  logic [ALU_W-1:0]  ac_alu   [PE_NUM];
  logic [SEL_W-1:0]  ac_sel_a [PE_NUM];
  logic [SEL_W-1:0]  ac_sel_b [PE_NUM];
  logic [SE_W-1:0]   ac_se    [PE_NUM];
  logic [DATA_W-1:0] ac_ca    [PE_NUM];
  logic [DATA_W-1:0] ac_cb    [PE_NUM];

  always_comb begin
    state_n  = state;
    cnt_n    = cnt;
    len_n    = len_q;
    pend_n   = pend;
    st_lat_n = st_lat;
    done_n   = 1'b0;
    case (state)
      S_IDLE: begin
        if (commit) begin
          state_n = S_SWAP;
          if (start) begin
            st_lat_n = 1'b1;
            len_n    = run_len;
          end
        end else if (start) begin
          if (run_len == '0) begin
            done_n = 1'b1;
          end else begin
            state_n = S_RUN;
            cnt_n   = run_len - LEN_W'(1);
          end
        end
      end
      S_RUN: begin
        if (commit) pend_n = 1'b1;
        if (cnt == '0) begin
          state_n = pend_n ? S_SWAP : S_IDLE;
        end else begin
          cnt_n = cnt - LEN_W'(1);
        end
      end
      S_SWAP: begin
        pend_n   = 1'b0;
        st_lat_n = 1'b0;
        state_n  = S_IDLE;
        // START latched alongside COMMIT runs on the freshly swapped bank
        if (st_lat) begin
          if (len_q == '0) begin
            done_n = 1'b1;
          end else begin
            state_n = S_RUN;
            cnt_n   = len_q - LEN_W'(1);
          end
        end
      end
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      cnt       <= '0;
      len_q     <= '0;
      pend      <= 1'b0;
      st_lat    <= 1'b0;
      run       <= 1'b0;
      done      <= 1'b0;
      busy      <= 1'b0;
      cfg_ready <= 1'b1;
    end else begin
      state     <= state_n;
      cnt       <= cnt_n;
      len_q     <= len_n;
      pend      <= pend_n;
      st_lat    <= st_lat_n;
      run       <= (state_n == S_RUN);
      done      <= done_n || ((state_n == S_RUN) && (cnt_n == '0));
      busy      <= (state_n != S_IDLE) || pend_n;
      cfg_ready <= (state_n != S_SWAP);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < PE_NUM; i++) begin
        sh_alu[i]   <= '0;
        sh_sel_a[i] <= '0;
        sh_sel_b[i] <= '0;
        sh_se[i]    <= '0;
        sh_ca[i]    <= '0;
        sh_cb[i]    <= '0;
      end
    end else if (cfg_valid && cfg_ready) begin
      case (cfg_field)
        3'd0:    sh_alu[cfg_pe]   <= cfg_data[ALU_W-1:0];
        3'd1:    sh_sel_a[cfg_pe] <= cfg_data[SEL_W-1:0];
        3'd2:    sh_sel_b[cfg_pe] <= cfg_data[SEL_W-1:0];
        3'd3:    sh_se[cfg_pe]    <= cfg_data[SE_W-1:0];
        3'd4:    sh_ca[cfg_pe]    <= cfg_data;
        3'd5:    sh_cb[cfg_pe]    <= cfg_data;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < PE_NUM; i++) begin
        ac_alu[i]   <= '0;
        ac_sel_a[i] <= '0;
        ac_sel_b[i] <= '0;
        ac_se[i]    <= '0;
        ac_ca[i]    <= '0;
        ac_cb[i]    <= '0;
      end
    end else if (state == S_SWAP) begin
      for (int i = 0; i < PE_NUM; i++) begin
        ac_alu[i]   <= sh_alu[i];
        ac_sel_a[i] <= sh_sel_a[i];
        ac_sel_b[i] <= sh_sel_b[i];
        ac_se[i]    <= sh_se[i];
        ac_ca[i]    <= sh_ca[i];
        ac_cb[i]    <= sh_cb[i];
      end
    end
  end

  for (genvar i = 0; i < PE_NUM; i++) begin : g_pack
    assign conf_alu[i*ALU_W +: ALU_W]    = ac_alu[i];
    assign conf_sel_a[i*SEL_W +: SEL_W]  = ac_sel_a[i];
    assign conf_sel_b[i*SEL_W +: SEL_W]  = ac_sel_b[i];
    assign conf_se[i*SE_W +: SE_W]       = ac_se[i];
    assign const_a[i*DATA_W +: DATA_W]   = ac_ca[i];
    assign const_b[i*DATA_W +: DATA_W]   = ac_cb[i];
  end

`ifdef CONF_READBACK_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_data <= '0;
    end else begin
      case (rd_field)
        3'd0:    rd_data <= {{(DATA_W-ALU_W){1'b0}}, ac_alu[rd_pe]};
        3'd1:    rd_data <= {{(DATA_W-SEL_W){1'b0}}, ac_sel_a[rd_pe]};
        3'd2:    rd_data <= {{(DATA_W-SEL_W){1'b0}}, ac_sel_b[rd_pe]};
        3'd3:    rd_data <= {{(DATA_W-SE_W){1'b0}}, ac_se[rd_pe]};
        3'd4:    rd_data <= ac_ca[rd_pe];
        3'd5:    rd_data <= ac_cb[rd_pe];
        default: rd_data <= '0;
      endcase
    end
  end
`endif

endmodule

`default_nettype wire

// File: tb/tb_col_conf_ctrl.sv
// tb_col_conf_ctrl: directed self-checking bench for col_conf_ctrl.
`default_nettype none

module tb_col_conf_ctrl;

  logic         clk = 1'b0;
  logic         rst;
  logic         cfg_valid;
  logic         cfg_ready;
  logic [2:0]   cfg_pe;
  logic [2:0]   cfg_field;
  logic [15:0]  cfg_data;
  logic         commit;
  logic         start;
  logic [15:0]  run_len;
  logic [31:0]  conf_alu;
  logic [23:0]  conf_sel_a;
  logic [23:0]  conf_sel_b;
  logic [15:0]  conf_se;
  logic [127:0] const_a;
  logic [127:0] const_b;
  logic         run;
  logic         done;
  logic         busy;
`ifdef CONF_READBACK_EN
  logic [2:0]   rd_pe;
  logic [2:0]   rd_field;
  logic [15:0]  rd_data;
`endif

  int checks   = 0;
  int failures = 0;

  col_conf_ctrl dut (
    .clk        (clk),
    .rst        (rst),
    .cfg_valid  (cfg_valid),
    .cfg_ready  (cfg_ready),
    .cfg_pe     (cfg_pe),
    .cfg_field  (cfg_field),
    .cfg_data   (cfg_data),
    .commit     (commit),
    .start      (start),
    .run_len    (run_len),
    .conf_alu   (conf_alu),
    .conf_sel_a (conf_sel_a),
    .conf_sel_b (conf_sel_b),
    .conf_se    (conf_se),
    .const_a    (const_a),
    .const_b    (const_b),
`ifdef CONF_READBACK_EN
    .rd_pe      (rd_pe),
    .rd_field   (rd_field),
    .rd_data    (rd_data),
`endif
    .run        (run),
    .done       (done),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wr(input logic [2:0] pe, input logic [2:0] fld, input logic [15:0] d);
    cfg_valid = 1'b1; cfg_pe = pe; cfg_field = fld; cfg_data = d;
    tick();
    cfg_valid = 1'b0;
  endtask

  initial begin
    rst = 1'b1; cfg_valid = 0; cfg_pe = 0; cfg_field = 0; cfg_data = 0;
    commit = 0; start = 0; run_len = 0;
`ifdef CONF_READBACK_EN
    rd_pe = 0; rd_field = 0;
`endif
    tick(); tick();
    rst = 1'b0;
    tick();

    // 1. reset state
    chk("rst_alu",   conf_alu, 0);
    chk("rst_sela",  conf_sel_a, 0);
    chk("rst_selb",  conf_sel_b, 0);
    chk("rst_se",    conf_se, 0);
    chk("rst_ca",    const_a, 0);
    chk("rst_cb",    const_b, 0);
    chk("rst_run",   run, 0);
    chk("rst_done",  done, 0);
    chk("rst_busy",  busy, 0);
    chk("rst_ready", cfg_ready, 1);

    // 2. shadow writes, invisible until commit
    wr(3'd3, 3'd0, 16'h0005);
    wr(3'd1, 3'd1, 16'h000F);   // truncated to 3'h7
    wr(3'd7, 3'd5, 16'h1234);
    wr(3'd2, 3'd6, 16'hFFFF);   // discarded
    tick();
    chk("shadow_only_alu", conf_alu, 0);
    chk("shadow_only_cb",  const_b, 0);
    commit = 1'b1;
    tick();
    commit = 1'b0;
    chk("swap_ready_low", cfg_ready, 0);
    chk("swap_alu_old",   conf_alu, 0);
    chk("swap_busy",      busy, 1);
    tick();
    chk("commit_alu",  conf_alu, 32'h0000_5000);
    chk("commit_sela", conf_sel_a, 24'h000038);
    chk("commit_selb", conf_sel_b, 0);
    chk("commit_cb",   const_b, {16'h1234, 112'h0});
    chk("commit_ready", cfg_ready, 1);
`ifdef CONF_READBACK_EN
    rd_pe = 3'd3; rd_field = 3'd0;
    tick();
    chk("rd_alu3", rd_data, 16'h0005);
    rd_field = 3'd7;
    tick();
    chk("rd_f7", rd_data, 16'h0000);
`endif

    // 3. run of 4 cycles; START during RUN ignored
    run_len = 16'd4; start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("r4_run%0d", i),  run, 1);
      chk($sformatf("r4_done%0d", i), done, (i == 3));
      chk($sformatf("r4_busy%0d", i), busy, 1);
      if (i == 1) start = 1'b1;
      tick();
      start = 1'b0;
    end
    chk("r4_run_end",  run, 0);
    chk("r4_done_end", done, 0);
    chk("r4_busy_end", busy, 0);

    // 4. mid-run write + commit deferred until after DONE
    run_len = 16'd6; start = 1'b1;
    tick();
    start = 1'b0;
    cfg_valid = 1'b1; cfg_pe = 3'd0; cfg_field = 3'd4; cfg_data = 16'hBEEF; commit = 1'b1;
    tick();
    cfg_valid = 1'b0; commit = 1'b0;
    chk("mid_ca_hold", const_a, 0);
    chk("mid_busy",    busy, 1);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk($sformatf("mid_ca%0d", i),    const_a, 0);
      chk($sformatf("mid_ready%0d", i), cfg_ready, 1);
    end
    chk("mid_last_run",  run, 1);
    chk("mid_last_done", done, 1);
    tick();
    chk("mid_swap_run",   run, 0);
    chk("mid_swap_ready", cfg_ready, 0);
    chk("mid_swap_busy",  busy, 1);
    chk("mid_swap_ca",    const_a, 0);
    tick();
    chk("mid_new_ca",  const_a, 128'hBEEF);
    chk("mid_ready_1", cfg_ready, 1);
    chk("mid_busy_0",  busy, 0);

    // 5a. zero length run
    run_len = 16'd0; start = 1'b1;
    tick();
    start = 1'b0;
    chk("z_done", done, 1);
    chk("z_run",  run, 0);
    tick();
    chk("z_done_end", done, 0);
    chk("z_run_end",  run, 0);

    // 5b. COMMIT+START: swap precedes run
    wr(3'd5, 3'd0, 16'h000A);
    commit = 1'b1; start = 1'b1; run_len = 16'd2;
    tick();
    commit = 1'b0; start = 1'b0;
    chk("cs_swap_run",   run, 0);
    chk("cs_swap_ready", cfg_ready, 0);
    chk("cs_swap_alu",   conf_alu, 32'h0000_5000);
    tick();
    chk("cs_run1",  run, 1);
    chk("cs_done1", done, 0);
    chk("cs_alu",   conf_alu, 32'h00A0_5000);
    tick();
    chk("cs_run2",  run, 1);
    chk("cs_done2", done, 1);
    tick();
    chk("cs_run_end", run, 0);
    chk("cs_busy",    busy, 0);

    // 6. asynchronous reset during a run
    run_len = 16'd11; start = 1'b1;
    tick();
    start = 1'b0;
    chk("ar_run", run, 1);
    #2 rst = 1'b1;
    #1;
    chk("ar_run_low", run, 0);
    chk("ar_done",    done, 0);
    chk("ar_alu",     conf_alu, 0);
    chk("ar_ca",      const_a, 0);
    chk("ar_cb",      const_b, 0);
    rst = 1'b0;
    tick();
    chk("ar_busy",  busy, 0);
    chk("ar_ready", cfg_ready, 1);
    chk("ar_done2", done, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
